// File: rtl/cvd_pkg.sv
// rtl/cvd_pkg.sv - shared state encoding and power width for the throw controller
package cvd_pkg;

  localparam int POWER_W = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_CHARGING = 3'd2,
    S_FLIGHT   = 3'd3,
    S_DONE     = 3'd4
  } throw_state_t;

endpackage

// File: rtl/power_meter.sv
// rtl/power_meter.sv - ping-pong power meter, one step every CHARGE_DIV enabled cycles
module power_meter
  import cvd_pkg::*;
#(
  parameter int POWER_MAX  = 100,
  parameter int CHARGE_DIV = 250000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  output logic [POWER_W-1:0] power
);

  localparam int                 DIV_W    = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CHARGE_DIV - 1);
  localparam logic [POWER_W-1:0] PMAX     = POWER_W'(POWER_MAX);

  logic [DIV_W-1:0] div_q;
  logic             dir_down_q;
  logic             step;

  assign step = enable && (div_q == DIV_LAST);

  // Direction flips on the step that touches an end, so the ends are held
  // for one step period only and the range is never exceeded.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_q      <= '0;
      dir_down_q <= 1'b0;
      power      <= '0;
    end else if (enable) begin
      div_q <= step ? '0 : div_q + 1'b1;
      if (step) begin
        if (PMAX == '0) begin
          power <= '0;
        end else if (!dir_down_q) begin
          if (power >= PMAX) begin
            power      <= power - 1'b1;
            dir_down_q <= 1'b1;
          end else begin
            power <= power + 1'b1;
          end
        end else begin
          if (power == '0) begin
            power      <= power + 1'b1;
            dir_down_q <= 1'b0;
          end else begin
            power <= power - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/throw_ctrl.sv
// rtl/throw_ctrl.sv - turn/charge/launch/flight FSM; THROW_TIMEOUT_EN adds a flight watchdog
module throw_ctrl
  import cvd_pkg::*;
#(
  parameter int          POWER_MAX      = 100,
  parameter int          CHARGE_DIV     = 250000,
  parameter logic [31:0] FLIGHT_TIMEOUT = 32'd130000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dog_turn,
  input  logic               cat_turn,
  input  logic               fire_btn,
  input  logic               proj_landed,
  output logic [POWER_W-1:0] power,
  output logic [POWER_W-1:0] throw_power,
  output logic               launch,
  output logic               throw_side,
  output logic               turn_done_dog,
  output logic               turn_done_cat,
  output logic               busy,
  output logic [2:0]         state_throw
);

  throw_state_t       state_q, state_d;
  logic               fire_prev_q;
  logic               fire_rise;
  logic               side_turn;
  logic               flight_timeout;
  logic               side_d;
  logic               launch_d;
  logic [POWER_W-1:0] throw_power_d;
  logic [POWER_W-1:0] meter_power;

  assign fire_rise = fire_btn && !fire_prev_q;
  assign side_turn = throw_side ? cat_turn : dog_turn;

  // Meter is held cleared outside CHARGING, so entry always starts at 0, direction up.
  power_meter #(
    .POWER_MAX  (POWER_MAX),
    .CHARGE_DIV (CHARGE_DIV)
  ) u_power_meter (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != S_CHARGING),
    .enable ((state_q == S_CHARGING) && fire_btn),
    .power  (meter_power)
  );

`ifdef THROW_TIMEOUT_EN
  logic [31:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q != S_FLIGHT)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 32'd1;
    end
  end

  assign flight_timeout = (state_q == S_FLIGHT) && (wd_q == FLIGHT_TIMEOUT - 32'd1);
`else
  logic [31:0] unused_flight_timeout;

  assign unused_flight_timeout = FLIGHT_TIMEOUT;
  assign flight_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fire_prev_q <= 1'b0;
      throw_side  <= 1'b0;
      throw_power <= '0;
      launch      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_prev_q <= fire_btn;
      throw_side  <= side_d;
      throw_power <= throw_power_d;
      launch      <= launch_d;
    end
  end

  // Losing the turn for the latched side beats every other event in a turn.
  always_comb begin
    state_d       = state_q;
    side_d        = throw_side;
    launch_d      = 1'b0;
    throw_power_d = throw_power;
    unique case (state_q)
      S_IDLE: begin
        if (dog_turn ^ cat_turn) begin
          state_d = S_ARMED;
          side_d  = cat_turn;
        end
      end
      S_ARMED: begin
        if (!side_turn) begin
          state_d = S_IDLE;
        end else if (fire_rise) begin
          state_d = S_CHARGING;
        end
      end
      S_CHARGING: begin
        if (!side_turn) begin
          state_d = S_IDLE;
        end else if (!fire_btn) begin
          state_d       = S_FLIGHT;
          launch_d      = 1'b1;
          throw_power_d = meter_power;
        end
      end
      S_FLIGHT: begin
        if (!side_turn) begin
          state_d = S_IDLE;
        end else if (proj_landed || flight_timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign power         = (state_q == S_CHARGING) ? meter_power : '0;
  assign turn_done_dog = (state_q == S_DONE) && !throw_side;
  assign turn_done_cat = (state_q == S_DONE) && throw_side;
  assign busy          = (state_q != S_IDLE);
  assign state_throw   = state_q;

endmodule

// File: tb/tb_throw_ctrl.sv
// tb/tb_throw_ctrl.sv - randomized self-checking bench for throw_ctrl against a ping-pong model
module tb_throw_ctrl;
  import cvd_pkg::*;

  localparam int PMAX = 5;
  localparam int DIV  = 2;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dog_turn = 1'b0, cat_turn = 1'b0, fire_btn = 1'b0, proj_landed = 1'b0;
  logic [6:0] power, throw_power;
  logic       launch, throw_side, turn_done_dog, turn_done_cat, busy;
  logic [2:0] state_throw;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] tp_exp   = '0;

  always #5 clk = ~clk;

  throw_ctrl #(
    .POWER_MAX      (PMAX),
    .CHARGE_DIV     (DIV),
    .FLIGHT_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dog_turn      (dog_turn),
    .cat_turn      (cat_turn),
    .fire_btn      (fire_btn),
    .proj_landed   (proj_landed),
    .power         (power),
    .throw_power   (throw_power),
    .launch        (launch),
    .throw_side    (throw_side),
    .turn_done_dog (turn_done_dog),
    .turn_done_cat (turn_done_cat),
    .busy          (busy),
    .state_throw   (state_throw)
  );

  // Expected meter value after k enabled charging cycles: triangle wave of period 2*PMAX steps.
  function automatic logic [6:0] pp(input int k);
    int s, m;
    s = k / DIV;
    m = s % (2 * PMAX);
    return 7'((m <= PMAX) ? m : 2 * PMAX - m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input bit side);
    if (side) cat_turn = 1'b1; else dog_turn = 1'b1;
    tick();
    n_checks++;
    if (state_throw !== S_ARMED || busy !== 1'b1 || throw_side !== side || power !== 7'd0) begin
      n_fail++;
      $display("FAIL arm: state=%0d busy=%0b side=%0b power=%0d, expected state=%0d busy=1 side=%0b power=0",
               state_throw, busy, throw_side, power, S_ARMED, side);
    end
  endtask

  task automatic press();
    fire_btn = 1'b1;
    tick();
    n_checks++;
    if (state_throw !== S_CHARGING || power !== 7'd0) begin
      n_fail++;
      $display("FAIL press: state=%0d power=%0d, expected state=%0d power=0", state_throw, power, S_CHARGING);
    end
  endtask

  task automatic charge(input int hold, input int abort_at, input bit side, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < hold; k++) begin
      n_checks++;
      if (state_throw !== S_CHARGING || power !== pp(k)) begin
        n_fail++;
        $display("FAIL charge_power k=%0d: state=%0d power=%0d, expected state=%0d power=%0d",
                 k, state_throw, power, S_CHARGING, pp(k));
      end
      if (k == abort_at) begin
        if (side) cat_turn = 1'b0; else dog_turn = 1'b0;
        tick();
        n_checks++;
        if (state_throw !== S_IDLE || power !== 7'd0 || launch !== 1'b0 ||
            (turn_done_dog | turn_done_cat) !== 1'b0 || throw_power !== tp_exp) begin
          n_fail++;
          $display("FAIL abort_charging: state=%0d power=%0d launch=%0b done=%0b%0b tp=%0d, expected state=0 power=0 launch=0 done=00 tp=%0d",
                   state_throw, power, launch, turn_done_dog, turn_done_cat, throw_power, tp_exp);
        end
        fire_btn = 1'b0;
        aborted  = 1'b1;
        return;
      end
      tick();
    end
    n_checks++;
    if (power !== pp(hold)) begin
      n_fail++;
      $display("FAIL release_power: power=%0d, expected %0d", power, pp(hold));
    end
    fire_btn = 1'b0;
    tick();
    tp_exp = pp(hold);
    n_checks++;
    if (state_throw !== S_FLIGHT || launch !== 1'b1 || throw_power !== tp_exp ||
        power !== 7'd0 || throw_side !== side) begin
      n_fail++;
      $display("FAIL launch: state=%0d launch=%0b tp=%0d power=%0d side=%0b, expected state=%0d launch=1 tp=%0d power=0 side=%0b",
               state_throw, launch, throw_power, power, throw_side, S_FLIGHT, tp_exp, side);
    end
    tick();
    n_checks++;
    if (launch !== 1'b0 || state_throw !== S_FLIGHT) begin
      n_fail++;
      $display("FAIL launch_width: launch=%0b state=%0d, expected launch=0 state=%0d", launch, state_throw, S_FLIGHT);
    end
  endtask

  task automatic land(input bit side, input int delay);
    for (int i = 0; i < delay; i++) begin
      n_checks++;
      if (state_throw !== S_FLIGHT || (turn_done_dog | turn_done_cat) !== 1'b0 || launch !== 1'b0) begin
        n_fail++;
        $display("FAIL flight_wait i=%0d: state=%0d done=%0b%0b launch=%0b, expected state=%0d done=00 launch=0",
                 i, state_throw, turn_done_dog, turn_done_cat, launch, S_FLIGHT);
      end
      tick();
    end
    proj_landed = 1'b1;
    tick();
    proj_landed = 1'b0;
    n_checks++;
    if (state_throw !== S_DONE || turn_done_dog !== !side || turn_done_cat !== side) begin
      n_fail++;
      $display("FAIL turn_done: state=%0d dog=%0b cat=%0b, expected state=%0d dog=%0b cat=%0b",
               state_throw, turn_done_dog, turn_done_cat, S_DONE, !side, side);
    end
    if (side) cat_turn = 1'b0; else dog_turn = 1'b0;
    tick();
    n_checks++;
    if (state_throw !== S_IDLE || busy !== 1'b0 || (turn_done_dog | turn_done_cat) !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: state=%0d busy=%0b done=%0b%0b, expected state=0 busy=0 done=00",
               state_throw, busy, turn_done_dog, turn_done_cat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dog_turn = 1'b1; fire_btn = 1'b1; proj_landed = 1'b1;
    tick();
    n_checks++;
    if (state_throw !== S_IDLE || power !== 0 || throw_power !== 0 || launch !== 0 || throw_side !== 0 ||
        turn_done_dog !== 0 || turn_done_cat !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL reset: state=%0d power=%0d tp=%0d launch=%0b side=%0b done=%0b%0b busy=%0b, expected all 0",
               state_throw, power, throw_power, launch, throw_side, turn_done_dog, turn_done_cat, busy);
    end
    rst = 1'b0; dog_turn = 1'b0; fire_btn = 1'b0; proj_landed = 1'b0;
    tick();
    tp_exp = '0;
  endtask

  task automatic test_charge_dog();
    bit ab;
    arm(1'b0);
    press();
    charge(13, -1, 1'b0, ab);
    land(1'b0, 2);
  endtask

  task automatic test_held_fire_cat();
    bit ab;
    fire_btn = 1'b1;
    tick();
    arm(1'b1);
    for (int i = 0; i < 4; i++) begin
      proj_landed = (i == 2);
      tick();
      n_checks++;
      if (state_throw !== S_ARMED || power !== 7'd0) begin
        n_fail++;
        $display("FAIL held_fire i=%0d: state=%0d power=%0d, expected state=%0d power=0", i, state_throw, power, S_ARMED);
      end
    end
    proj_landed = 1'b0;
    fire_btn = 1'b0;
    tick();
    n_checks++;
    if (state_throw !== S_ARMED) begin
      n_fail++;
      $display("FAIL release_armed: state=%0d, expected %0d", state_throw, S_ARMED);
    end
    press();
    charge(9, -1, 1'b1, ab);
    land(1'b1, 1);
  endtask

  task automatic test_abort();
    bit ab;
    arm(1'b1);
    press();
    charge(7, 4, 1'b1, ab);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (state_throw !== S_IDLE || launch !== 1'b0 || (turn_done_dog | turn_done_cat) !== 1'b0 || throw_power !== tp_exp) begin
        n_fail++;
        $display("FAIL post_abort i=%0d: state=%0d launch=%0b done=%0b%0b tp=%0d, expected idle, no pulses, tp=%0d",
                 i, state_throw, launch, turn_done_dog, turn_done_cat, throw_power, tp_exp);
      end
    end
  endtask

  task automatic test_both_turns();
    dog_turn = 1'b1; cat_turn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fire_btn = i[0];
      tick();
      n_checks++;
      if (state_throw !== S_IDLE || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL both_turns i=%0d: state=%0d busy=%0b, expected state=0 busy=0", i, state_throw, busy);
      end
    end
    dog_turn = 1'b0; cat_turn = 1'b0; fire_btn = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit ab;
    arm(1'b0);
    press();
    charge(3, -1, 1'b0, ab);
`ifdef THROW_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) begin
      n_checks++;
      if (state_throw !== S_FLIGHT) begin
        n_fail++;
        $display("FAIL timeout_wait cycle=%0d: state=%0d, expected %0d", i, state_throw, S_FLIGHT);
      end
      tick();
    end
    n_checks++;
    if (state_throw !== S_DONE || turn_done_dog !== 1'b1 || turn_done_cat !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: state=%0d dog=%0b cat=%0b, expected state=%0d dog=1 cat=0",
               state_throw, turn_done_dog, turn_done_cat, S_DONE);
    end
    dog_turn = 1'b0;
    tick();
`else
    for (int i = 1; i <= 100; i++) begin
      n_checks++;
      if (state_throw !== S_FLIGHT || (turn_done_dog | turn_done_cat) !== 1'b0) begin
        n_fail++;
        $display("FAIL no_timeout cycle=%0d: state=%0d done=%0b%0b, expected state=%0d done=00",
                 i, state_throw, turn_done_dog, turn_done_cat, S_FLIGHT);
      end
      tick();
    end
    dog_turn = 1'b0;
    tick();
`endif
    n_checks++;
    if (state_throw !== S_IDLE || (turn_done_dog | turn_done_cat) !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_exit: state=%0d done=%0b%0b, expected state=0 done=00", state_throw, turn_done_dog, turn_done_cat);
    end
  endtask

  task automatic test_random();
    bit side, ab;
    int hold, mode, abort_at;
    for (int t = 0; t < 16; t++) begin
      side     = 1'($urandom_range(0, 1));
      hold     = $urandom_range(0, 30);
      mode     = $urandom_range(0, 3);
      abort_at = (mode == 2 && hold > 0) ? $urandom_range(0, hold - 1) : -1;
      arm(side);
      press();
      charge(hold, abort_at, side, ab);
      if (ab) begin
        tick();
      end else if (mode == 3) begin
        if (side) cat_turn = 1'b0; else dog_turn = 1'b0;
        tick();
        n_checks++;
        if (state_throw !== S_IDLE || (turn_done_dog | turn_done_cat) !== 1'b0 || power !== 0 || throw_power !== tp_exp) begin
          n_fail++;
          $display("FAIL abort_flight t=%0d: state=%0d done=%0b%0b power=%0d tp=%0d, expected idle, no done, power 0, tp=%0d",
                   t, state_throw, turn_done_dog, turn_done_cat, power, throw_power, tp_exp);
        end
        tick();
      end else begin
        land(side, $urandom_range(0, 8));
      end
    end
  endtask

  task automatic test_reset_in_flight();
    arm(1'b0);
    fire_btn = 1'b1;
    tick();
    tick();
    fire_btn = 1'b0;
    tick();
    n_checks++;
    if (launch !== 1'b1 || state_throw !== S_FLIGHT) begin
      n_fail++;
      $display("FAIL pre_reset_launch: launch=%0b state=%0d, expected launch=1 state=%0d", launch, state_throw, S_FLIGHT);
    end
    rst = 1'b1; proj_landed = 1'b1;
    tick();
    n_checks++;
    if (state_throw !== S_IDLE || power !== 0 || throw_power !== 0 || launch !== 0 || throw_side !== 0 ||
        turn_done_dog !== 0 || turn_done_cat !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL reset_in_flight: state=%0d power=%0d tp=%0d launch=%0b side=%0b done=%0b%0b busy=%0b, expected all 0",
               state_throw, power, throw_power, launch, throw_side, turn_done_dog, turn_done_cat, busy);
    end
    rst = 1'b0; proj_landed = 1'b0; dog_turn = 1'b0;
    tick();
    tp_exp = '0;
  endtask

  initial begin
    test_reset();
    test_charge_dog();
    test_held_fire_cat();
    test_abort();
    test_both_turns();
    test_timeout();
    test_random();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/throw_ctrl.md
THROW_CTRL -- requirements
Module: throw_ctrl

Interface
REQ-001 Parameter POWER_MAX, default 100: top of the power meter range; power is 7-bit.
REQ-002 Parameter CHARGE_DIV, default 250000: clock cycles per power step; ≥1.
REQ-003 Parameter FLIGHT_TIMEOUT, default 130000000: watchdog limit in cycles for the projectile flight; 32-bit count.
REQ-004 clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 dog_turn / cat_turn  in  1 each  turn levels from the game FSM.
REQ-007 fire_btn  in  1  fire button level, already debounced and synchronous.
REQ-008 proj_landed  in  1  one-cycle pulse from the projectile engine.
REQ-009 power  out  7  live meter value while charging.
REQ-010 throw_power  out  7  power latched at launch.
REQ-011 launch  out  1  one-cycle pulse that starts the projectile.
REQ-012 throw_side  out  1  side of the current throw: 0 = dog, 1 = cat.
REQ-013 turn_done_dog / turn_done_cat  out  1 each  one-cycle end-of-turn pulses to the game FSM.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 state_throw  out  3  current state encoding, for debug and display.

Function
REQ-016 States SHALL be IDLE, ARMED, CHARGING, FLIGHT and DONE.
REQ-017 IDLE: when exactly one of dog_turn and cat_turn is high, the block SHALL latch throw_side and go to ARMED. When both or neither are high, it SHALL stay in IDLE.
REQ-018 ARMED: on a fire_btn rising edge (against a registered previous value) the block SHALL clear power, set the direction to up and go to CHARGING. A button already held when the turn starts SHALL NOT count as a press.
REQ-019 CHARGING: while fire_btn is high, power SHALL step by 1 every CHARGE_DIV cycles in ping-pong order 0,1,…,POWER_MAX,POWER_MAX-1,…,0,1,… It SHALL reverse direction exactly at the ends, never exceeding POWER_MAX and never going below 0.
REQ-020 CHARGING with fire_btn low: in one cycle the block SHALL set throw_power to the current power, pulse launch and go to FLIGHT. Releasing on the same cycle as a step SHALL latch the pre-step value.
REQ-021 FLIGHT: on proj_landed the block SHALL go to DONE. A proj_landed pulse in any other state SHALL be ignored.
REQ-022 DONE: the block SHALL pulse turn_done_dog if throw_side is 0, otherwise turn_done_cat, for exactly one cycle, then go to IDLE.
REQ-023 Abort: in ARMED, CHARGING or FLIGHT, if the turn input for the latched side goes low, the block SHALL go to IDLE next cycle. It SHALL produce no turn_done pulse, zero power and leave throw_power unchanged.
REQ-024 The two turn_done outputs SHALL never be high together. launch SHALL pulse at most once per turn.
REQ-025 power SHALL read 0 outside CHARGING.

Reset
REQ-026 On rst, the block SHALL enter IDLE. power, throw_power, launch, throw_side, both turn_done outputs and busy SHALL be 0; the step divider, the direction, the previous-fire register and the watchdog SHALL be cleared.
REQ-027 Reset SHALL take priority over all events, including a launch or turn_done in the same cycle.

Configuration
REQ-028 Macro THROW_TIMEOUT_EN defined: after FLIGHT_TIMEOUT cycles in FLIGHT without proj_landed, the block SHALL go to DONE as if the projectile had landed. The watchdog SHALL restart on each entry to FLIGHT.
REQ-029 Macro THROW_TIMEOUT_EN undefined: FLIGHT SHALL wait indefinitely and no watchdog logic SHALL be synthesised. Ports SHALL be identical in both builds.

Structure
REQ-030 The state enum (throw_state_t, 3-bit) and the power width constant SHALL live in the shared package cvd_pkg.
REQ-031 The ping-pong counter SHALL be a sub-module power_meter, with inputs clear and enable and output power; throw_ctrl owns the FSM.

Verification (POWER_MAX=5, CHARGE_DIV=2, FLIGHT_TIMEOUT=20)
REQ-032 dog_turn=1, fire press held 14 cycles then released -> power sequence 0,1,2,3,4,5,4,…; throw_power equals the value at release; launch is one cycle; throw_side=0.
REQ-033 After launch, proj_landed pulse -> turn_done_dog high exactly one cycle later, for one cycle; busy=0 the cycle after.
REQ-034 fire_btn held across the start of cat_turn -> no charging until release and re-press; turn_done_cat at the end.
REQ-035 cat_turn dropped mid-CHARGING -> IDLE next cycle, no launch, no turn_done, power=0.
REQ-036 THROW_TIMEOUT_EN defined, no proj_landed -> DONE after 20 FLIGHT cycles; undefined -> still in FLIGHT at cycle 100.
REQ-037 dog_turn and cat_turn both 1 -> stays IDLE; rst asserted in FLIGHT -> all outputs 0 next cycle.
